// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter_if
// Description : Bundle of the signals around the shared memory-port arbiter.
//               Fetch request/response, load/store request/response, the
//               memory-array port and the fault report all live here.
//               slave  : the arbiter's view (requests in, grants/port out)
//               master : the environment's view (requesters + memory arrays)
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
);
    // fetch requester
    logic                  if_req;
    logic [DATA_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    // load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    // memory array port
    logic [MEM_AW-1:0]     mem_addr;
    logic                  mem_sel;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // fault report
    logic                  fault;
    logic [DATA_WIDTH-1:0] fault_addr;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_sel, mem_we, mem_wdata, fault, fault_addr
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_sel, mem_we, mem_wdata, fault, fault_addr
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one text/data memory port between the instruction
//               fetch and load/store requesters. Round-robin arbitration on
//               simultaneous requests, alignment/window/write-protect checks,
//               byte-address to word-index translation, fixed-latency access.
// Ports       : clk    - clock, rising edge
//               rst_n  - synchronous active-low reset
//               bus_io - imem_port_arbiter_if.slave: if_* fetch handshake,
//                        d_* load/store handshake, mem_* array port,
//                        fault/fault_addr rejected-access report
// Revision    : 1.0 - initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_AW      = 10,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE   = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] DATA_BASE   = 32'h1001_0000,
    parameter int                    MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_port_arbiter_if.slave bus_io
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FAULT  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Bytes covered by one segment window.
    localparam logic [DATA_WIDTH-1:0] SEG_BYTES = DATA_WIDTH'(1) << (MEM_AW + 2);
    localparam logic [2:0]            LAST_CNT  = 3'(MEM_LATENCY - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;           // 1 = load/store owns the port
    logic                  last_was_d_q, last_was_d_d; // round-robin pointer
    logic [MEM_AW-1:0]     idx_q, idx_d;
    logic                  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_WIDTH-1:0] fault_addr_q, fault_addr_d;

    // Candidate request as seen in IDLE.
    logic                  w_pick_d;
    logic [DATA_WIDTH-1:0] w_addr;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_off_text;
    logic [DATA_WIDTH-1:0] w_off_data;
    logic                  w_in_text;
    logic                  w_in_data;
    logic                  w_bad;

    always_comb begin
        // Load/store wins when alone, or on a tie when fetch was served last.
        w_pick_d   = bus_io.d_req && (!bus_io.if_req || !last_was_d_q);
        w_addr     = w_pick_d ? bus_io.d_addr : bus_io.if_addr;
        w_we       = w_pick_d && bus_io.d_we;
        // Wrapping subtraction plus one unsigned compare gives the window test.
        w_off_text = w_addr - TEXT_BASE;
        w_off_data = w_addr - DATA_BASE;
        w_in_text  = (w_off_text < SEG_BYTES);
        w_in_data  = (w_off_data < SEG_BYTES);
        w_bad      = (w_addr[1:0] != 2'b00)
                   || (!w_pick_d && !w_in_text)
                   || (w_pick_d && !w_in_text && !w_in_data)
                   || (w_we && w_in_text);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_was_d_d = last_was_d_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        fault_addr_d = fault_addr_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                if (bus_io.if_req || bus_io.d_req) begin
                    owner_d      = w_pick_d;
                    last_was_d_d = w_pick_d;
                    sel_d        = !w_in_text;
                    idx_d        = w_in_text ? w_off_text[MEM_AW+1:2] : w_off_data[MEM_AW+1:2];
                    we_d         = w_we;
                    wdata_d      = w_we ? bus_io.d_wdata : '0;
                    if (w_bad) begin
                        state_d      = ST_FAULT;
                        fault_addr_d = w_addr;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        d_rdata_d = we_q ? '0 : bus_io.mem_rdata;
                    end else begin
                        if_rdata_d = bus_io.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_FAULT: begin
                state_d = ST_RESP;
                if (owner_q) begin
                    d_rdata_d = '0;
                end else begin
                    if_rdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_was_d_q <= 1'b1;
            idx_q        <= '0;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= 3'd0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_was_d_q <= last_was_d_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    logic w_access;
    logic w_first;

    assign w_access = (state_q == ST_ACCESS);
    // The grant pulse marks the first cycle after acceptance: either the
    // first ACCESS cycle or the single FAULT cycle.
    assign w_first  = (w_access && (cnt_q == 3'd0)) || (state_q == ST_FAULT);

    assign bus_io.if_gnt     = w_first && !owner_q;
    assign bus_io.d_gnt      = w_first && owner_q;
    assign bus_io.if_rvalid  = (state_q == ST_RESP) && !owner_q;
    assign bus_io.d_rvalid   = (state_q == ST_RESP) && owner_q;
    assign bus_io.if_rdata   = if_rdata_q;
    assign bus_io.d_rdata    = d_rdata_q;
    assign bus_io.mem_addr   = w_access ? idx_q : '0;
    assign bus_io.mem_sel    = w_access && sel_q;
    assign bus_io.mem_we     = w_access && we_q && (cnt_q == 3'd0);
    assign bus_io.mem_wdata  = w_access ? wdata_q : '0;
    assign bus_io.fault      = (state_q == ST_FAULT);
    assign bus_io.fault_addr = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Self-checking bench for imem_port_arbiter. A latency-1
//               instance runs directed and random traffic against a reference
//               model and scoreboard; a latency-3 instance covers multi-cycle
//               access and reset during an access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

    localparam int          DW        = 32;
    localparam int          AW        = 10;
    localparam int          LAT       = 1;
    localparam int          LAT2      = 3;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;
    localparam longint      SEG       = 4 * 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n    = 1'b0;
    logic rst2_n   = 1'b0;
    bit   mem_fill = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    imem_port_arbiter_if #(.DATA_WIDTH(DW), .MEM_AW(AW)) bus ();
    imem_port_arbiter_if #(.DATA_WIDTH(DW), .MEM_AW(AW)) bus2 ();

    imem_port_arbiter #(.DATA_WIDTH(DW), .MEM_AW(AW), .TEXT_BASE(TEXT_BASE),
                        .DATA_BASE(DATA_BASE), .MEM_LATENCY(LAT))
        dut (.clk(clk), .rst_n(rst_n), .bus_io(bus.slave));

    imem_port_arbiter #(.DATA_WIDTH(DW), .MEM_AW(AW), .TEXT_BASE(TEXT_BASE),
                        .DATA_BASE(DATA_BASE), .MEM_LATENCY(LAT2))
        dut2 (.clk(clk), .rst_n(rst2_n), .bus_io(bus2.slave));

    function automatic logic [31:0] text_word(input int i);
        return 32'h2008_0003 + 32'(i);
    endfunction

    function automatic logic [31:0] data_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Environment memories: text is read-only content, data is a real array.
    logic [31:0] dmem [1024];
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= data_word(i);
        end else if (bus.mem_we && bus.mem_sel) begin
            dmem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata  = bus.mem_sel  ? dmem[bus.mem_addr] : text_word(int'(bus.mem_addr));
    assign bus2.mem_rdata = bus2.mem_sel ? (32'hD000_0000 | 32'(bus2.mem_addr))
                                         : text_word(int'(bus2.mem_addr));

    // Reference model
    typedef struct {
        bit          flt;
        logic [31:0] addr;
        int          idx;
        bit          sel;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] ref_dmem [1024];
    exp_t        if_q[$];
    exp_t        d_q[$];
    int          gcyc_if, gcyc_d;
    bit          glog_own[$];
    int          glog_cyc[$];

    function automatic exp_t predict(input bit is_d, input bit we,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        longint unsigned a = addr;
        bit in_text = (a >= TEXT_BASE) && (a < longint'(TEXT_BASE) + SEG);
        bit in_data = (a >= DATA_BASE) && (a < longint'(DATA_BASE) + SEG);
        e.addr = addr; e.we = is_d && we; e.wdata = wdata;
        e.flt = 1'b0; e.idx = 0; e.sel = 1'b0; e.rdata = '0;
        if (addr[1:0] != 2'b00)                  e.flt = 1'b1;
        else if (!is_d && !in_text)              e.flt = 1'b1;
        else if (is_d && !in_text && !in_data)   e.flt = 1'b1;
        else if (is_d && we && in_text)          e.flt = 1'b1;
        if (!e.flt) begin
            if (in_text) begin
                e.idx   = int'((a - TEXT_BASE) / 4);
                e.rdata = text_word(e.idx);
            end else begin
                e.idx = int'((a - DATA_BASE) / 4);
                e.sel = 1'b1;
                if (e.we) ref_dmem[e.idx] = wdata;
                else      e.rdata = ref_dmem[e.idx];
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic on_grant(input bit o);
        exp_t e;
        if ((o && d_q.size() == 0) || (!o && if_q.size() == 0)) begin
            checks++; errors++;
            $display("FAIL %s: got grant expected none outstanding", o ? "d_gnt" : "if_gnt");
            return;
        end
        e = o ? d_q[0] : if_q[0];
        if (o) gcyc_d = cyc; else gcyc_if = cyc;
        glog_own.push_back(o);
        glog_cyc.push_back(cyc);
        chk("gnt_fault", 32'(bus.fault), 32'(e.flt));
        if (e.flt) begin
            chk("fault_addr", bus.fault_addr, e.addr);
            chk("fault_mem_we", 32'(bus.mem_we), 32'd0);
        end else begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.idx));
            chk("mem_sel", 32'(bus.mem_sel), 32'(e.sel));
            chk("mem_we", 32'(bus.mem_we), 32'(e.we));
            if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
    endtask

    task automatic on_resp(input bit o);
        exp_t e;
        if ((o && d_q.size() == 0) || (!o && if_q.size() == 0)) begin
            checks++; errors++;
            $display("FAIL %s: got rvalid expected none outstanding", o ? "d_rvalid" : "if_rvalid");
            return;
        end
        e = o ? d_q.pop_front() : if_q.pop_front();
        chk(o ? "d_rdata" : "if_rdata", o ? bus.d_rdata : bus.if_rdata, e.rdata);
        chk("resp_latency", 32'(cyc - (o ? gcyc_d : gcyc_if)), e.flt ? 32'd1 : 32'(LAT));
    endtask

    // Monitor for the latency-1 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !mem_fill) begin
                chk("gnt_exclusive", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
                chk("stray_mem_we", 32'(bus.mem_we & ~bus.d_gnt), 32'd0);
                chk("stray_fault", 32'(bus.fault & ~(bus.if_gnt | bus.d_gnt)), 32'd0);
                if (bus.if_gnt)    on_grant(1'b0);
                if (bus.d_gnt)     on_grant(1'b1);
                if (bus.if_rvalid) on_resp(1'b0);
                if (bus.d_rvalid)  on_resp(1'b1);
            end
        end
    end

    // Requester drivers: hold req until gnt, then wait for the response.
    task automatic fetch_txn(input logic [31:0] addr);
        int n;
        if_q.push_back(predict(1'b0, 1'b0, addr, '0));
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 100);
        chk("if_gnt_wait", 32'(bus.if_gnt), 32'd1);
        bus.if_req  = 1'b0;
        bus.if_addr = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.if_rvalid && n < 20);
        chk("if_rvalid_wait", 32'(bus.if_rvalid), 32'd1);
    endtask

    task automatic data_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        d_q.push_back(predict(1'b1, we, addr, wdata));
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_req   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_gnt && n < 100);
        chk("d_gnt_wait", 32'(bus.d_gnt), 32'd1);
        bus.d_req   = 1'b0;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_rvalid && n < 20);
        chk("d_rvalid_wait", 32'(bus.d_rvalid), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr(input bit is_d);
        int unsigned k    = $urandom_range(0, 9);
        logic [31:0] base = (is_d && $urandom_range(0, 2) != 0) ? DATA_BASE : TEXT_BASE;
        case (k)
            0:       return base + 32'h1000;
            1:       return base - 32'd4;
            2:       return base + 32'hFFC;
            3:       return base + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
            4:       return $urandom;
            5, 6, 7: return base + 4 * $urandom_range(0, 15);
            default: return base + 4 * $urandom_range(0, 1023);
        endcase
    endfunction

    function automatic bit sig2(input int s);
        case (s)
            0:       return bus2.if_gnt;
            1:       return bus2.d_gnt;
            2:       return bus2.if_rvalid;
            3:       return bus2.d_rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait2(input int s, input string name, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!sig2(s) && n < 50);
        chk(name, 32'(sig2(s)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int nrv;
        bus.if_req = 0;  bus.if_addr = '0; bus.d_req = 0;  bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus2.if_req = 0; bus2.if_addr = '0; bus2.d_req = 0; bus2.d_we = 0;
        bus2.d_addr = '0; bus2.d_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_dmem[i] = data_word(i);
        repeat (3) @(negedge clk);
        mem_fill = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_fault_addr", bus.fault_addr, 32'd0);

        // Directed transactions
        fetch_txn(32'h0040_0008);
        data_txn(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        data_txn(1'b0, 32'h1001_0004, 32'h0);
        data_txn(1'b1, 32'h0040_0000, 32'h1234_5678);
        fetch_txn(32'h0040_0002);
        fetch_txn(32'h0040_1000);
        fetch_txn(32'h0040_0FFC);
        data_txn(1'b0, 32'h1001_1000, 32'h0);
        data_txn(1'b0, 32'h1001_0FFC, 32'h0);

        // Both requesting continuously from reset: strict alternation, IF first
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        glog_own.delete(); glog_cyc.delete();
        fork
            repeat (4) fetch_txn(TEXT_BASE + 4 * $urandom_range(0, 1023));
            repeat (4) data_txn(1'b0, DATA_BASE + 4 * $urandom_range(0, 1023), '0);
        join
        chk("rr_grant_count", 32'(glog_own.size()), 32'd8);
        for (int i = 0; i < glog_own.size(); i++) begin
            chk("rr_owner", 32'(glog_own[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'(LAT + 2));
        end

        // Random concurrent traffic
        fork
            repeat (40) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                fetch_txn(rand_addr(1'b0));
            end
            repeat (40) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                data_txn(1'($urandom_range(0, 1)), rand_addr(1'b1), $urandom);
            end
        join
        @(negedge clk);
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("d_q_drained", 32'(d_q.size()), 32'd0);

        // Latency-3 instance
        rst2_n = 1'b1;
        @(negedge clk);
        bus2.if_addr = TEXT_BASE + 1; bus2.if_req = 1'b1;
        wait2(0, "l3_fault_gnt", n);
        chk("l3_fault_pulse", 32'(bus2.fault), 32'd1);
        chk("l3_fault_addr", bus2.fault_addr, TEXT_BASE + 1);
        bus2.if_req = 1'b0;
        wait2(2, "l3_fault_rvalid", n);
        chk("l3_fault_latency", 32'(n), 32'd1);

        bus2.if_addr = TEXT_BASE + 12; bus2.if_req = 1'b1;
        wait2(0, "l3_fetch_gnt", n);
        chk("l3_fetch_mem_addr", 32'(bus2.mem_addr), 32'd3);
        bus2.if_req = 1'b0;
        wait2(2, "l3_fetch_rvalid", n);
        chk("l3_fetch_latency", 32'(n), 32'(LAT2));
        chk("l3_fetch_rdata", bus2.if_rdata, text_word(3));

        bus2.d_we = 1'b1; bus2.d_addr = DATA_BASE + 8; bus2.d_wdata = 32'hCAFE_F00D;
        bus2.d_req = 1'b1;
        wait2(1, "l3_store_gnt", n);
        chk("l3_store_we1", 32'(bus2.mem_we), 32'd1);
        chk("l3_store_sel", 32'(bus2.mem_sel), 32'd1);
        chk("l3_store_addr", 32'(bus2.mem_addr), 32'd2);
        chk("l3_store_wdata", bus2.mem_wdata, 32'hCAFE_F00D);
        bus2.d_req = 1'b0;
        @(negedge clk);
        chk("l3_store_we2", 32'(bus2.mem_we), 32'd0);
        chk("l3_store_addr2", 32'(bus2.mem_addr), 32'd2);
        @(negedge clk);
        chk("l3_store_we3", 32'(bus2.mem_we), 32'd0);
        chk("l3_store_early_rvalid", 32'(bus2.d_rvalid), 32'd0);
        @(negedge clk);
        chk("l3_store_rvalid", 32'(bus2.d_rvalid), 32'd1);
        chk("l3_store_rdata", bus2.d_rdata, 32'd0);

        // Reset during the second ACCESS cycle
        bus2.if_addr = TEXT_BASE + 16; bus2.if_req = 1'b1;
        wait2(0, "l3_rst_gnt", n);
        bus2.if_req = 1'b0;
        @(negedge clk);
        chk("l3_rst_access2_addr", 32'(bus2.mem_addr), 32'd4);
        rst2_n = 1'b0;
        @(negedge clk);
        chk("l3_rst_if_rdata", bus2.if_rdata, 32'd0);
        chk("l3_rst_fault_addr", bus2.fault_addr, 32'd0);
        chk("l3_rst_mem_addr", 32'(bus2.mem_addr), 32'd0);
        chk("l3_rst_ctl", 32'({bus2.if_gnt, bus2.d_gnt, bus2.if_rvalid, bus2.d_rvalid,
                               bus2.mem_sel, bus2.mem_we, bus2.fault}), 32'd0);
        rst2_n = 1'b1;
        nrv = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus2.if_rvalid || bus2.d_rvalid) nrv++;
        end
        chk("l3_rst_no_rvalid", 32'(nrv), 32'd0);

        bus2.if_addr = TEXT_BASE + 20; bus2.d_we = 1'b0; bus2.d_addr = DATA_BASE;
        bus2.if_req = 1'b1; bus2.d_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus2.if_gnt && !bus2.d_gnt && n < 50);
        chk("l3_tie_if_gnt", 32'(bus2.if_gnt), 32'd1);
        chk("l3_tie_d_gnt", 32'(bus2.d_gnt), 32'd0);
        bus2.if_req = 1'b0;
        wait2(1, "l3_tie_d_gnt_later", n);
        bus2.d_req = 1'b0;
        wait2(3, "l3_tie_d_rvalid", n);
        chk("l3_tie_d_rdata", bus2.d_rdata, 32'hD000_0000);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one program/data memory port between the instruction-fetch requester and the load/store requester of the MIPS core.
- Arbitrates between the two requesters, checks each access, and translates byte addresses into word indices.
  - Text segment base is 0x0040_0000; data segment base is 0x1001_0000.
- Drives the memory port for a fixed number of cycles, then returns read data over a simple req/gnt/rvalid handshake.
- Sits between the core's fetch/LSU logic and the text/data memory arrays.

Parameters:
- DATA_WIDTH, 32, width of data words and of requester byte addresses.
- MEM_AW, 10, memory word-index width; each segment holds 1024 words.
- TEXT_BASE, 32'h0040_0000, byte base address of the text segment.
- DATA_BASE, 32'h1001_0000, byte base address of the data segment.
- MEM_LATENCY, 1, cycles the memory port is held per access; legal range 1..7.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- if_req, input, 1, fetch request; held until if_gnt.
- if_addr, input, DATA_WIDTH, fetch byte address.
- if_gnt, output, 1, one-cycle grant pulse to fetch.
- if_rvalid, output, 1, one-cycle response pulse to fetch.
- if_rdata, output, DATA_WIDTH, fetch response data.
- d_req, input, 1, load/store request; held until d_gnt.
- d_we, input, 1, 1 = store, 0 = load.
- d_addr, input, DATA_WIDTH, load/store byte address.
- d_wdata, input, DATA_WIDTH, store data.
- d_gnt, output, 1, one-cycle grant pulse to load/store.
- d_rvalid, output, 1, one-cycle response pulse to load/store.
- d_rdata, output, DATA_WIDTH, load response data; 0 for stores.
- mem_addr, output, MEM_AW, word index = (addr - segment base) >> 2.
- mem_sel, output, 1, 0 = text array, 1 = data array.
- mem_we, output, 1, write strobe; asserted only in the first ACCESS cycle.
- mem_wdata, output, DATA_WIDTH, write data.
- mem_rdata, input, DATA_WIDTH, combinational read data from the selected array.
- fault, output, 1, one-cycle pulse for a rejected access.
- fault_addr, output, DATA_WIDTH, byte address of the most recent fault; holds its value between faults.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - State returns to IDLE and every output is 0, including fault_addr.
  - The last-grant pointer is set to DATA, so fetch wins the first tie.
  - Any in-flight transaction is dropped and no rvalid is issued for it.
- FSM states: IDLE, ACCESS, FAULT, RESP.
- IDLE:
  - Requests are sampled only in IDLE; requests in any other state are ignored.
  - If only one requester is asserting req, it wins.
  - If both assert req in the same cycle, the requester not granted last wins (round-robin); the pointer is updated on each grant.
  - The winner's address, we and wdata are latched at edge T; its gnt is high during cycle T+1.
- Checks on the latched request, in priority order; the first failing check sends the FSM to FAULT:
  - addr[1:0] != 0.
  - Fetch address outside [TEXT_BASE, TEXT_BASE + 4*2^MEM_AW).
  - Data address outside both the text and data windows.
  - Store to the text window (text is read-only).
- Legal requests go to ACCESS:
  - ACCESS lasts MEM_LATENCY cycles, starting at T+1.
  - mem_addr, mem_sel and mem_wdata are stable for the whole ACCESS period.
  - mem_we is high in the first ACCESS cycle only, and only for stores.
  - mem_rdata is captured on the final ACCESS edge; the FSM then goes to RESP.
  - A cycle counter of 3 bits runs during ACCESS.
- FAULT (one cycle, T+1):
  - fault pulses and fault_addr is loaded.
  - The memory port stays idle (mem_we = 0); the FSM goes to RESP.
- RESP (one cycle):
  - The owner's rvalid pulses, with rdata = captured word (or 0 for stores and faults).
  - The FSM returns to IDLE.
- Latency:
  - Legal access: gnt at T+1, rvalid at T+1+MEM_LATENCY.
  - Faulted access: gnt at T+1, rvalid at T+2.
  - Minimum back-to-back spacing is MEM_LATENCY+2 cycles per transaction.
- Outputs outside active states:
  - mem_addr, mem_sel and mem_wdata are 0 when not in ACCESS.
  - rdata outputs hold their value between responses.
- Address arithmetic is modulo 2^DATA_WIDTH; the window checks use unsigned compares.
- An address at exactly base + 4*2^MEM_AW is out of range; base + 4*(2^MEM_AW - 1) is legal.

Test Plan:
- Single fetch, if_addr = 0x0040_0008, mem_rdata = 0x2008_0005 → if_gnt at T+1; mem_addr = 2, mem_sel = 0 at T+1; if_rvalid at T+2 with if_rdata = 0x2008_0005.
- if_req and d_req asserted together continuously after reset → grants go IF, D, IF, D; each transaction is 3 cycles apart (MEM_LATENCY = 1).
- Store to d_addr = 0x1001_0004 with d_wdata = 0xDEAD_BEEF → mem_we high for exactly one cycle, with mem_sel = 1, mem_addr = 1; d_rvalid follows with d_rdata = 0.
- Store to 0x0040_0000 → fault pulse, fault_addr = 0x0040_0000, mem_we never asserted, d_rvalid at T+2.
- Fetch of 0x0040_0002, then fetch of 0x0040_1000 → two faults, no memory access; fetch of 0x0040_0FFC → legal, mem_addr = 1023.
- MEM_LATENCY = 3, with rst_n driven low during the second ACCESS cycle → all outputs 0 next cycle, no rvalid; the next simultaneous request is granted to IF.
